// File: rtl/hacd_pkg.sv
// Shared types and constants for the hawk AXI arbiter.
package hacd_pkg;

   localparam int HAWK_ARB_MAX_REQ = 8;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
   } hawk_arb_rd_state_t;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_REQ  = 2'd1,
      WR_RESP = 2'd2
   } hawk_arb_wr_state_t;

endpackage

// File: rtl/hawk_rr_arb.sv
// Request vector + pointer -> one-hot grant and its index.
// Round-robin from ptr_i by default; with HAWK_ARB_PRIO_EN defined the
// lowest asserted index wins and ptr_i is ignored.
module hawk_rr_arb
   import hacd_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int IDX_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               vld_o
);

   // Scan from the farthest candidate to the nearest so the nearest hit wins.
   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] cand;
      sum   = '0;
      cand  = '0;
      idx_o = '0;
      vld_o = 1'b0;
`ifdef HAWK_ARB_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = IDX_W'(i);
            vld_o = 1'b1;
         end
      end
`else
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum  = {1'b0, ptr_i} + (IDX_W+1)'(k);
         cand = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                             : sum[IDX_W-1:0];
         if (req_i[cand]) begin
            idx_o = cand;
            vld_o = 1'b1;
         end
      end
`endif
      gnt_o = vld_o ? (NUM_REQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/hawk_axi_arb.sv
// Shares one AXI4 master port among NUM_REQ hawk requesters. Read and write
// channels are arbitrated independently, one single-beat transaction each.
// Define HAWK_ARB_PRIO_EN for fixed priority (index 0 highest, no rr pointers).
module hawk_axi_arb
   import hacd_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 512,
   parameter int STRB_W  = DATA_W / 8
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_arvalid_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_araddr_i,
   output logic [NUM_REQ-1:0]        req_arready_o,
   output logic [NUM_REQ-1:0]        req_rvalid_o,
   output logic [DATA_W-1:0]         req_rdata_o,
   output logic [1:0]                req_rresp_o,
   input  logic [NUM_REQ-1:0]        req_awvalid_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_awaddr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   input  logic [NUM_REQ*STRB_W-1:0] req_wstrb_i,
   output logic [NUM_REQ-1:0]        req_awready_o,
   output logic [NUM_REQ-1:0]        req_bvalid_o,
   output logic [1:0]                req_bresp_o,
   output logic                      m_arvalid_o,
   output logic [ADDR_W-1:0]         m_araddr_o,
   input  logic                      m_arready_i,
   input  logic                      m_rvalid_i,
   input  logic [DATA_W-1:0]         m_rdata_i,
   input  logic [1:0]                m_rresp_i,
   input  logic                      m_rlast_i,
   output logic                      m_rready_o,
   output logic                      m_awvalid_o,
   output logic [ADDR_W-1:0]         m_awaddr_o,
   input  logic                      m_awready_i,
   output logic                      m_wvalid_o,
   output logic [DATA_W-1:0]         m_wdata_o,
   output logic [STRB_W-1:0]         m_wstrb_o,
   output logic                      m_wlast_o,
   input  logic                      m_wready_i,
   input  logic                      m_bvalid_i,
   input  logic [1:0]                m_bresp_i,
   output logic                      m_bready_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   hawk_arb_rd_state_t  rd_state_q, rd_state_d;
   logic [IDX_W-1:0]    rd_idx_q, rd_idx_d, rd_ptr, rd_gnt_idx;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic [1:0]          rd_resp_q, rd_resp_d;
   logic [NUM_REQ-1:0]  rvalid_q, rvalid_d, rd_gnt;
   logic                rd_any;

   hawk_arb_wr_state_t  wr_state_q, wr_state_d;
   logic [IDX_W-1:0]    wr_idx_q, wr_idx_d, wr_ptr, wr_gnt_idx;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [STRB_W-1:0]   wr_strb_q, wr_strb_d;
   logic [1:0]          wr_resp_q, wr_resp_d;
   logic [NUM_REQ-1:0]  bvalid_q, bvalid_d, wr_gnt;
   logic                wr_any, aw_done_q, aw_done_d, w_done_q, w_done_d;

   hawk_rr_arb #(.NUM_REQ(NUM_REQ)) u_rd_arb (
      .req_i(req_arvalid_i), .ptr_i(rd_ptr), .gnt_o(rd_gnt), .idx_o(rd_gnt_idx), .vld_o(rd_any)
   );

   hawk_rr_arb #(.NUM_REQ(NUM_REQ)) u_wr_arb (
      .req_i(req_awvalid_i), .ptr_i(wr_ptr), .gnt_o(wr_gnt), .idx_o(wr_gnt_idx), .vld_o(wr_any)
   );

`ifdef HAWK_ARB_PRIO_EN
   assign rd_ptr = '0;
   assign wr_ptr = '0;
`else
   logic [IDX_W-1:0] rd_ptr_q, wr_ptr_q;
   assign rd_ptr = rd_ptr_q;
   assign wr_ptr = wr_ptr_q;

   // Pointers advance past the granted index only when a grant is taken.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         if (rd_state_q == RD_IDLE && rd_any)
            rd_ptr_q <= (rd_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : rd_gnt_idx + 1'b1;
         if (wr_state_q == WR_IDLE && wr_any)
            wr_ptr_q <= (wr_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : wr_gnt_idx + 1'b1;
      end
   end
`endif

   // Read FSM: grant, issue AR, absorb R beats, forward the last one.
   always_comb begin
      rd_state_d    = rd_state_q;
      rd_idx_d      = rd_idx_q;
      rd_addr_d     = rd_addr_q;
      rd_data_d     = rd_data_q;
      rd_resp_d     = rd_resp_q;
      rvalid_d      = '0;
      req_arready_o = '0;
      m_arvalid_o   = 1'b0;
      m_rready_o    = 1'b0;
      case (rd_state_q)
         RD_IDLE: if (rd_any) begin
            req_arready_o = rd_gnt;
            rd_idx_d      = rd_gnt_idx;
            rd_addr_d     = req_araddr_i[rd_gnt_idx*ADDR_W +: ADDR_W];
            rd_state_d    = RD_ADDR;
         end
         RD_ADDR: begin
            m_arvalid_o = 1'b1;
            if (m_arready_i) rd_state_d = RD_DATA;
         end
         RD_DATA: begin
            m_rready_o = 1'b1;
            if (m_rvalid_i) begin
               rd_data_d = m_rdata_i;
               rd_resp_d = m_rresp_i;
               if (m_rlast_i) begin
                  rvalid_d   = NUM_REQ'(1) << rd_idx_q;
                  rd_state_d = RD_IDLE;
               end
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Write FSM: grant, issue AW and W independently, wait for B.
   always_comb begin
      wr_state_d    = wr_state_q;
      wr_idx_d      = wr_idx_q;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      wr_strb_d     = wr_strb_q;
      wr_resp_d     = wr_resp_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      bvalid_d      = '0;
      req_awready_o = '0;
      m_awvalid_o   = 1'b0;
      m_wvalid_o    = 1'b0;
      m_bready_o    = 1'b0;
      case (wr_state_q)
         WR_IDLE: if (wr_any) begin
            req_awready_o = wr_gnt;
            wr_idx_d      = wr_gnt_idx;
            wr_addr_d     = req_awaddr_i[wr_gnt_idx*ADDR_W +: ADDR_W];
            wr_data_d     = req_wdata_i[wr_gnt_idx*DATA_W +: DATA_W];
            wr_strb_d     = req_wstrb_i[wr_gnt_idx*STRB_W +: STRB_W];
            aw_done_d     = 1'b0;
            w_done_d      = 1'b0;
            wr_state_d    = WR_REQ;
         end
         WR_REQ: begin
            m_awvalid_o = !aw_done_q;
            m_wvalid_o  = !w_done_q;
            aw_done_d   = aw_done_q | m_awready_i;
            w_done_d    = w_done_q | m_wready_i;
            if (aw_done_d && w_done_d) begin
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               wr_state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            m_bready_o = 1'b1;
            if (m_bvalid_i) begin
               wr_resp_d  = m_bresp_i;
               bvalid_d   = NUM_REQ'(1) << wr_idx_q;
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // State and payload registers for both channels.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_state_q <= RD_IDLE;
         rd_idx_q   <= '0;
         rd_addr_q  <= '0;
         rd_data_q  <= '0;
         rd_resp_q  <= '0;
         rvalid_q   <= '0;
         wr_state_q <= WR_IDLE;
         wr_idx_q   <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_strb_q  <= '0;
         wr_resp_q  <= '0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         bvalid_q   <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_idx_q   <= rd_idx_d;
         rd_addr_q  <= rd_addr_d;
         rd_data_q  <= rd_data_d;
         rd_resp_q  <= rd_resp_d;
         rvalid_q   <= rvalid_d;
         wr_state_q <= wr_state_d;
         wr_idx_q   <= wr_idx_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_strb_q  <= wr_strb_d;
         wr_resp_q  <= wr_resp_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         bvalid_q   <= bvalid_d;
      end
   end

   assign req_rvalid_o = rvalid_q;
   assign req_rdata_o  = rd_data_q;
   assign req_rresp_o  = rd_resp_q;
   assign req_bvalid_o = bvalid_q;
   assign req_bresp_o  = wr_resp_q;
   assign m_araddr_o   = rd_addr_q;
   assign m_awaddr_o   = wr_addr_q;
   assign m_wdata_o    = wr_data_q;
   assign m_wstrb_o    = wr_strb_q;
   assign m_wlast_o    = m_wvalid_o;

endmodule

// File: tb/tb_hawk_axi_arb.sv
// Directed bench for hawk_axi_arb (NUM_REQ=2). Inputs change on the falling
// edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_hawk_axi_arb;
   import hacd_pkg::*;

   localparam int N  = 2;
   localparam int AW = 64;
   localparam int DW = 512;
   localparam int SW = DW / 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_arvalid_i, req_arready_o, req_rvalid_o;
   logic [N*AW-1:0] req_araddr_i, req_awaddr_i;
   logic [DW-1:0]   req_rdata_o;
   logic [1:0]      req_rresp_o, req_bresp_o;
   logic [N-1:0]    req_awvalid_i, req_awready_o, req_bvalid_o;
   logic [N*DW-1:0] req_wdata_i;
   logic [N*SW-1:0] req_wstrb_i;
   logic            m_arvalid_o, m_arready_i, m_rvalid_i, m_rlast_i, m_rready_o;
   logic [AW-1:0]   m_araddr_o, m_awaddr_o;
   logic [DW-1:0]   m_rdata_i, m_wdata_o;
   logic [1:0]      m_rresp_i, m_bresp_i;
   logic            m_awvalid_o, m_awready_i, m_wvalid_o, m_wlast_o, m_wready_i;
   logic [SW-1:0]   m_wstrb_o;
   logic            m_bvalid_i, m_bready_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hawk_axi_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_arvalid_i(req_arvalid_i), .req_araddr_i(req_araddr_i), .req_arready_o(req_arready_o),
      .req_rvalid_o(req_rvalid_o), .req_rdata_o(req_rdata_o), .req_rresp_o(req_rresp_o),
      .req_awvalid_i(req_awvalid_i), .req_awaddr_i(req_awaddr_i), .req_wdata_i(req_wdata_i),
      .req_wstrb_i(req_wstrb_i), .req_awready_o(req_awready_o), .req_bvalid_o(req_bvalid_o),
      .req_bresp_o(req_bresp_o),
      .m_arvalid_o(m_arvalid_o), .m_araddr_o(m_araddr_o), .m_arready_i(m_arready_i),
      .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
      .m_rlast_i(m_rlast_i), .m_rready_o(m_rready_o),
      .m_awvalid_o(m_awvalid_o), .m_awaddr_o(m_awaddr_o), .m_awready_i(m_awready_i),
      .m_wvalid_o(m_wvalid_o), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
      .m_wlast_o(m_wlast_o), .m_wready_i(m_wready_i),
      .m_bvalid_i(m_bvalid_i), .m_bresp_i(m_bresp_i), .m_bready_o(m_bready_o)
   );

   task automatic idle_inputs();
      req_arvalid_i = '0; req_araddr_i = '0;
      req_awvalid_i = '0; req_awaddr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
      m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0; m_rlast_i = 1'b0;
      m_awready_i = 1'b0; m_wready_i = 1'b0; m_bvalid_i = 1'b0; m_bresp_i = '0;
   endtask

   // Stimulus only: one read with an immediately ready slave, single beat.
   task automatic rd_txn(input logic [N-1:0] req, input logic [DW-1:0] d, input logic [1:0] resp,
                         output logic [N-1:0] gnt, output logic [N-1:0] vld,
                         output logic [DW-1:0] rd);
      @(negedge clk); req_arvalid_i = req; m_arready_i = 1'b1; #1 gnt = req_arready_o;
      @(negedge clk); req_arvalid_i = '0;
      @(negedge clk); m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rlast_i = 1'b1;
      m_rdata_i = d; m_rresp_i = resp;
      @(negedge clk); m_rvalid_i = 1'b0; m_rlast_i = 1'b0; #1 vld = req_rvalid_o; rd = req_rdata_o;
   endtask

   task automatic test_reset();
      logic [11:0] flags;
      rst_n = 1'b0;
      idle_inputs();
      #2;
      flags = {req_arready_o, req_rvalid_o, req_awready_o, req_bvalid_o,
               m_arvalid_o, m_rready_o, m_awvalid_o, m_wvalid_o};
      n_chk++;
      if (flags !== 12'h0) begin
         $display("FAIL reset_ctrl got=%h want=0", flags); n_fail++;
      end
      n_chk++;
      if ({req_rdata_o, m_araddr_o, m_awaddr_o, m_wstrb_o, req_rresp_o, req_bresp_o} !== '0) begin
         $display("FAIL reset_data got nonzero want=0"); n_fail++;
      end
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_read_single();
      logic [DW-1:0] a5 = {64{8'hA5}};
      @(negedge clk);
      req_arvalid_i = 2'b10; req_araddr_i = {64'h8000_0040, 64'h0}; m_arready_i = 1'b1;
      #1 n_chk++;
      if (req_arready_o !== 2'b10) begin
         $display("FAIL rd1_arready got=%b want=10", req_arready_o); n_fail++;
      end
      @(negedge clk); req_arvalid_i = '0;
      #1 n_chk++;
      if ({m_arvalid_o, m_araddr_o} !== {1'b1, 64'h8000_0040}) begin
         $display("FAIL rd1_ar got=%b/%h want=1/80000040", m_arvalid_o, m_araddr_o); n_fail++;
      end
      @(negedge clk); m_arready_i = 1'b0;
      m_rvalid_i = 1'b1; m_rlast_i = 1'b1; m_rdata_i = a5; m_rresp_i = AXI_RESP_OKAY;
      #1 n_chk++;
      if ({m_rready_o, m_arvalid_o, req_rvalid_o} !== 4'b1000) begin
         $display("FAIL rd1_rdata_phase got=%b%b%b want=1000", m_rready_o, m_arvalid_o, req_rvalid_o);
         n_fail++;
      end
      @(negedge clk); m_rvalid_i = 1'b0; m_rlast_i = 1'b0; m_rdata_i = '0;
      #1 n_chk++;
      if ({req_rvalid_o, req_rresp_o} !== {2'b10, AXI_RESP_OKAY} || req_rdata_o !== a5) begin
         $display("FAIL rd1_resp got=%b/%b/%h want=10/00/a5..", req_rvalid_o, req_rresp_o,
                  req_rdata_o[63:0]);
         n_fail++;
      end
      @(negedge clk); #1 n_chk++;
      if (req_rvalid_o !== 2'b00) begin
         $display("FAIL rd1_pulse_width got=%b want=00", req_rvalid_o); n_fail++;
      end
   endtask

   task automatic test_rr_reads();
      logic [N-1:0]  g, v, exp_g;
      logic [DW-1:0] rd;
      req_araddr_i = {64'h1000, 64'h2000};
      for (int k = 0; k < 4; k++) begin
         rd_txn(2'b11, DW'(k + 16), AXI_RESP_OKAY, g, v, rd);
`ifdef HAWK_ARB_PRIO_EN
         exp_g = 2'b01;
`else
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
         n_chk++;
         if (g !== exp_g || v !== exp_g || rd !== DW'(k + 16)) begin
            $display("FAIL rr_txn%0d gnt=%b vld=%b data=%0h want gnt/vld=%b data=%0h",
                     k, g, v, rd[31:0], exp_g, k + 16);
            n_fail++;
         end
      end
   endtask

   task automatic test_write_split();
      logic [DW-1:0] wd = {16{32'hDEAD_BEEF}};
      logic [SW-1:0] ws = 64'h0000_00FF_0000_F00F;
      @(negedge clk);
      req_awvalid_i = 2'b01; req_awaddr_i = {64'h0, 64'h4000_0080};
      req_wdata_i = {{DW{1'b0}}, wd}; req_wstrb_i = {{SW{1'b0}}, ws};
      #1 n_chk++;
      if (req_awready_o !== 2'b01) begin
         $display("FAIL wr_awready got=%b want=01", req_awready_o); n_fail++;
      end
      @(negedge clk); req_awvalid_i = '0; req_wdata_i = '0; req_wstrb_i = '0; m_awready_i = 1'b1;
      #1 n_chk++;
      if ({m_awvalid_o, m_wvalid_o, m_wlast_o} !== 3'b111 || m_awaddr_o !== 64'h4000_0080 ||
          m_wdata_o !== wd || m_wstrb_o !== ws) begin
         $display("FAIL wr_issue got=%b%b%b addr=%h strb=%h want=111 40000080 %h",
                  m_awvalid_o, m_wvalid_o, m_wlast_o, m_awaddr_o, m_wstrb_o, ws);
         n_fail++;
      end
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk); m_awready_i = 1'b0; m_wready_i = (c == 4);
         #1 n_chk++;
         if ({m_awvalid_o, m_wvalid_o, m_wlast_o, m_bready_o} !== 4'b0110) begin
            $display("FAIL wr_hold_c%0d got=%b%b%b%b want=0110", c, m_awvalid_o, m_wvalid_o,
                     m_wlast_o, m_bready_o);
            n_fail++;
         end
      end
      @(negedge clk); m_wready_i = 1'b0; m_bvalid_i = 1'b1; m_bresp_i = AXI_RESP_OKAY;
      #1 n_chk++;
      if ({m_wvalid_o, m_bready_o, req_bvalid_o} !== 4'b0100) begin
         $display("FAIL wr_bphase got=%b%b%b want=0100", m_wvalid_o, m_bready_o, req_bvalid_o);
         n_fail++;
      end
      @(negedge clk); m_bvalid_i = 1'b0;
      #1 n_chk++;
      if ({req_bvalid_o, req_bresp_o} !== 4'b0100) begin
         $display("FAIL wr_bvalid got=%b/%b want=01/00", req_bvalid_o, req_bresp_o); n_fail++;
      end
      @(negedge clk); #1 n_chk++;
      if (req_bvalid_o !== 2'b00) begin
         $display("FAIL wr_bpulse_width got=%b want=00", req_bvalid_o); n_fail++;
      end
   endtask

   task automatic test_concurrent();
      @(negedge clk);
      req_arvalid_i = 2'b01; req_araddr_i = {64'h0, 64'h300};
      req_awvalid_i = 2'b10; req_awaddr_i = {64'h500, 64'h0};
      #1 n_chk++;
      if ({req_arready_o, req_awready_o} !== 4'b0110) begin
         $display("FAIL cc_accept got=%b/%b want=01/10", req_arready_o, req_awready_o); n_fail++;
      end
      @(negedge clk); req_arvalid_i = '0; req_awvalid_i = '0;
      m_arready_i = 1'b1; m_awready_i = 1'b1; m_wready_i = 1'b1;
      #1 n_chk++;
      if ({m_arvalid_o, m_awvalid_o, m_wvalid_o} !== 3'b111 || m_araddr_o !== 64'h300 ||
          m_awaddr_o !== 64'h500) begin
         $display("FAIL cc_issue got=%b%b%b ar=%h aw=%h want=111 300 500", m_arvalid_o,
                  m_awvalid_o, m_wvalid_o, m_araddr_o, m_awaddr_o);
         n_fail++;
      end
      @(negedge clk); m_arready_i = 1'b0; m_awready_i = 1'b0; m_wready_i = 1'b0;
      m_rvalid_i = 1'b1; m_rlast_i = 1'b1; m_rdata_i = DW'(64'h77);
      #1 n_chk++;
      if ({m_rready_o, m_bready_o} !== 2'b11) begin
         $display("FAIL cc_readies got=%b%b want=11", m_rready_o, m_bready_o); n_fail++;
      end
      @(negedge clk); m_rvalid_i = 1'b0; m_rlast_i = 1'b0; m_bvalid_i = 1'b1;
      m_bresp_i = AXI_RESP_OKAY;
      #1 n_chk++;
      if ({req_rvalid_o, req_bvalid_o} !== 4'b0100 || req_rdata_o !== DW'(64'h77)) begin
         $display("FAIL cc_rdone got=%b/%b want=01/00", req_rvalid_o, req_bvalid_o); n_fail++;
      end
      @(negedge clk); m_bvalid_i = 1'b0;
      #1 n_chk++;
      if ({req_rvalid_o, req_bvalid_o} !== 4'b0010) begin
         $display("FAIL cc_bdone got=%b/%b want=00/10", req_rvalid_o, req_bvalid_o); n_fail++;
      end
   endtask

   task automatic test_errors_multibeat();
      // Write answered with SLVERR, AW and W accepted together.
      @(negedge clk); req_awvalid_i = 2'b10; req_awaddr_i = {64'h600, 64'h0};
      @(negedge clk); req_awvalid_i = '0; m_awready_i = 1'b1; m_wready_i = 1'b1;
      @(negedge clk); m_awready_i = 1'b0; m_wready_i = 1'b0;
      m_bvalid_i = 1'b1; m_bresp_i = AXI_RESP_SLVERR;
      @(negedge clk); m_bvalid_i = 1'b0; m_bresp_i = AXI_RESP_OKAY;
      #1 n_chk++;
      if ({req_bvalid_o, req_bresp_o} !== 4'b1010) begin
         $display("FAIL err_bresp got=%b/%b want=10/10", req_bvalid_o, req_bresp_o); n_fail++;
      end
      // Two-beat read: only the last beat reaches the requester.
      @(negedge clk); req_arvalid_i = 2'b01; req_araddr_i = {64'h0, 64'h700};
      @(negedge clk); req_arvalid_i = '0; m_arready_i = 1'b1;
      @(negedge clk); m_arready_i = 1'b0; m_rvalid_i = 1'b1; m_rlast_i = 1'b0;
      m_rdata_i = DW'(64'h1111); m_rresp_i = AXI_RESP_OKAY;
      @(negedge clk); m_rlast_i = 1'b1; m_rdata_i = DW'(64'h2222); m_rresp_i = AXI_RESP_SLVERR;
      #1 n_chk++;
      if ({req_rvalid_o, m_rready_o} !== 3'b001) begin
         $display("FAIL mb_first_beat got=%b/%b want=00/1", req_rvalid_o, m_rready_o); n_fail++;
      end
      @(negedge clk); m_rvalid_i = 1'b0; m_rlast_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0;
      #1 n_chk++;
      if ({req_rvalid_o, req_rresp_o} !== 4'b0110 || req_rdata_o !== DW'(64'h2222)) begin
         $display("FAIL mb_last_beat got=%b/%b/%h want=01/10/2222", req_rvalid_o, req_rresp_o,
                  req_rdata_o[31:0]);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0]  g, v;
      logic [DW-1:0] rd;
      logic          seen;
      // req0 read moves the read pointer to 1, then reset lands in RD_DATA.
      @(negedge clk); req_arvalid_i = 2'b01; req_araddr_i = {64'h0, 64'h900};
      @(negedge clk); req_arvalid_i = '0; m_arready_i = 1'b1;
      @(negedge clk); m_arready_i = 1'b0;
      #1 n_chk++;
      if (m_rready_o !== 1'b1) begin
         $display("FAIL rst_pre_rready got=%b want=1", m_rready_o); n_fail++;
      end
      #1 rst_n = 1'b0;
      #1 n_chk++;
      if ({m_rready_o, m_arvalid_o, req_rvalid_o, req_arready_o} !== 6'b0) begin
         $display("FAIL rst_async got=%b%b%b%b want=0", m_rready_o, m_arvalid_o, req_rvalid_o,
                  req_arready_o);
         n_fail++;
      end
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1 if (req_rvalid_o !== 2'b00) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         $display("FAIL rst_no_pulse got=1 want=0"); n_fail++;
      end
      rd_txn(2'b11, DW'(64'h33), AXI_RESP_OKAY, g, v, rd);
      n_chk++;
      if (g !== 2'b01 || v !== 2'b01) begin
         $display("FAIL rst_ptr_zero gnt=%b vld=%b want=01/01", g, v); n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_read_single();
      test_rr_reads();
      test_write_split();
      test_concurrent();
      test_errors_multibeat();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog elapsed=200000ns want=finish earlier");
      $fatal(1, "watchdog");
   end

endmodule
